// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/EX controls, instruction memory data and IF/ID outputs.
interface fetch_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        MisalignD;

  // Surrounding pipeline: drives controls and memory data, observes fetch outputs.
  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignD
  );

  // Fetch stage itself.
  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignD
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage: program counter, IF/ID pipeline register and
// misaligned-redirect tagging.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);

  // Sequential PC increment, wrapping modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  logic [31:0] pc_p0;
  logic        pend_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pcplus4_p1;
  logic        vld_p1;
  logic        misalign_p1;
  logic        load_d;

  // IF/ID accepts a new instruction only when neither flushed nor stalled.
  assign load_d = !bus.FlushD && !bus.StallD;

  // ---- Stage p0: PC register and pending misalign tag ----
  // Redirect beats stall; pending tag is consumed by the next real load into D.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0   <= RESET_PC;
      pend_p0 <= 1'b0;
    end else if (bus.PCSrcE) begin
      pc_p0   <= {bus.PCTargetE[31:2], 2'b00};
      pend_p0 <= (bus.PCTargetE[1:0] != 2'b00);
    end else begin
      if (!bus.StallF) pc_p0 <= pc_inc(pc_p0);
      if (load_d)      pend_p0 <= 1'b0;
    end
  end

  // ---- Stage p1: IF/ID register ----
  // Flush inserts a bubble and beats stall; otherwise load unless stalled.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushD) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= 32'h0;
      pcplus4_p1  <= 32'h0;
      vld_p1      <= 1'b0;
      misalign_p1 <= 1'b0;
    end else if (!bus.StallD) begin
      instr_p1    <= bus.InstrF;
      pc_p1       <= pc_p0;
      pcplus4_p1  <= pc_inc(pc_p0);
      vld_p1      <= 1'b1;
      misalign_p1 <= pend_p0;
    end
  end

  assign bus.PCF       = pc_p0;
  assign bus.InstrD    = instr_p1;
  assign bus.PCD       = pc_p1;
  assign bus.PCPlus4D  = pcplus4_p1;
  assign bus.ValidD    = vld_p1;
  assign bus.MisalignD = misalign_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized control
// sequences checked against a cycle-level reference model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  fetch_if ifc ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  // Instruction memory: word content is a simple function of its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  assign ifc.InstrF = mem(ifc.PCF);

  // Reference model state (what the outputs should be after each edge).
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  logic        m_pend, m_vld, m_mis;

  function automatic logic [129:0] observed();
    return {ifc.PCF, ifc.InstrD, ifc.PCD, ifc.PCPlus4D, ifc.ValidD, ifc.MisalignD};
  endfunction

  function automatic logic [129:0] expected();
    return {m_pc, m_instr, m_pcd, m_pc4d, m_vld, m_mis};
  endfunction

  // Apply one cycle of inputs, advance the model by the stage rules, settle after the edge.
  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; ifc.StallF = sf; ifc.StallD = sd; ifc.FlushD = fd;
    ifc.PCSrcE = ps; ifc.PCTargetE = tgt;
    if (r) begin
      m_pc = 32'h0; m_pend = 1'b0;
      m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_vld = 0; m_mis = 0;
    end else begin
      if (fd) begin
        m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_vld = 0; m_mis = 0;
      end else if (!sd) begin
        m_instr = mem(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_vld = 1; m_mis = m_pend;
      end
      if (ps) m_pend = (tgt[1:0] != 2'b00);
      else if (!fd && !sd) m_pend = 1'b0;
      if (ps) m_pc = {tgt[31:2], 2'b00};
      else if (!sf) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (observed() !== {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", observed(), {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (observed() !== {32'h4, 32'hA000_0000, 32'h0, 32'h4, 1'b1, 1'b0}) begin
      failures++; $display("FAIL first_load got=%h exp=%h", observed(), {32'h4, 32'hA000_0000, 32'h0, 32'h4, 1'b1, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.PCF !== 32'h8 || ifc.InstrD !== 32'hA000_0004) begin
      failures++; $display("FAIL run_seq pcf=%h instr=%h exp 8/a0000004", ifc.PCF, ifc.InstrD);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0);
      checks++;
      if (ifc.PCF !== 32'h8 || ifc.InstrD !== 32'hA000_0004 || ifc.PCD !== 32'h4) begin
        failures++; $display("FAIL stall_hold pcf=%h instr=%h pcd=%h exp 8/a0000004/4", ifc.PCF, ifc.InstrD, ifc.PCD);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.PCF !== 32'hC || ifc.InstrD !== 32'hA000_0008) begin
      failures++; $display("FAIL stall_release pcf=%h instr=%h exp c/a0000008", ifc.PCF, ifc.InstrD);
    end
  endtask

  task automatic test_branch;
    drive(0, 0, 0, 0, 0, 0);  // PCF -> 0x10
    drive(0, 0, 0, 1, 1, 32'h40);
    checks++;
    if (ifc.PCF !== 32'h40 || ifc.InstrD !== 32'h13 || ifc.ValidD !== 1'b0) begin
      failures++; $display("FAIL branch_bubble pcf=%h instr=%h vld=%b exp 40/13/0", ifc.PCF, ifc.InstrD, ifc.ValidD);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (observed() !== {32'h44, 32'hA000_0040, 32'h40, 32'h44, 1'b1, 1'b0}) begin
      failures++; $display("FAIL branch_target got=%h exp=%h", observed(), {32'h44, 32'hA000_0040, 32'h40, 32'h44, 1'b1, 1'b0});
    end
  endtask

  task automatic test_misalign;
    drive(0, 0, 0, 1, 1, 32'h102);
    checks++;
    if (ifc.PCF !== 32'h100) begin
      failures++; $display("FAIL misalign_pc got=%h exp=00000100", ifc.PCF);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.PCD !== 32'h100 || ifc.MisalignD !== 1'b1) begin
      failures++; $display("FAIL misalign_tag pcd=%h mis=%b exp 100/1", ifc.PCD, ifc.MisalignD);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.PCD !== 32'h104 || ifc.MisalignD !== 1'b0) begin
      failures++; $display("FAIL misalign_clear pcd=%h mis=%b exp 104/0", ifc.PCD, ifc.MisalignD);
    end
    drive(0, 0, 0, 1, 1, 32'h102);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    checks++;
    if (ifc.ValidD !== 1'b0 || ifc.MisalignD !== 1'b0 || ifc.PCF !== 32'h100) begin
      failures++; $display("FAIL misalign_stalled vld=%b mis=%b pcf=%h exp 0/0/100", ifc.ValidD, ifc.MisalignD, ifc.PCF);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.PCD !== 32'h100 || ifc.MisalignD !== 1'b1 || ifc.ValidD !== 1'b1) begin
      failures++; $display("FAIL misalign_after_stall pcd=%h mis=%b vld=%b exp 100/1/1", ifc.PCD, ifc.MisalignD, ifc.ValidD);
    end
  endtask

  task automatic test_simultaneous;
    drive(0, 1, 1, 1, 1, 32'h200);
    checks++;
    if (ifc.PCF !== 32'h200 || ifc.InstrD !== 32'h13 || ifc.ValidD !== 1'b0 || ifc.PCD !== 32'h0) begin
      failures++; $display("FAIL all_controls pcf=%h instr=%h vld=%b pcd=%h exp 200/13/0/0", ifc.PCF, ifc.InstrD, ifc.ValidD, ifc.PCD);
    end
  endtask

  task automatic test_wrap_and_reset;
    drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (observed() !== {32'h0, 32'hA000_0000 + 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL pc_wrap got=%h exp=%h", observed(), {32'h0, 32'h9FFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0});
    end
    drive(0, 0, 0, 1, 1, 32'h307);
    drive(1, 0, 1, 0, 0, 0);
    checks++;
    if (observed() !== {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL midrun_reset got=%h exp=%h", observed(), {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.PCD !== 32'h0 || ifc.ValidD !== 1'b1 || ifc.MisalignD !== 1'b0) begin
      failures++; $display("FAIL reset_clears_pending pcd=%h vld=%b mis=%b exp 0/1/0", ifc.PCD, ifc.ValidD, ifc.MisalignD);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), tgt);
      checks++;
      if (observed() !== expected()) begin
        failures++; $display("FAIL random_cycle%0d got=%h exp=%h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.StallF = 0; ifc.StallD = 0; ifc.FlushD = 0; ifc.PCSrcE = 0; ifc.PCTargetE = 0;
    test_reset();
    test_stall();
    test_branch();
    test_misalign();
    test_simultaneous();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage RV32I pipeline. It holds the program counter and drives the word-aligned fetch address into the instruction memory. The memory returns the instruction word combinationally, and this block registers it into the IF/ID pipeline register. It applies branch/jump redirects from EX and stall/flush controls from the hazard unit, and tags any instruction fetched after a misaligned redirect target.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be word aligned.
NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in InstrD on reset or flush.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
StallF  input  1  hazard unit: hold PCF.
StallD  input  1  hazard unit: hold IF/ID register.
FlushD  input  1  hazard unit: replace IF/ID contents with a bubble.
PCSrcE  input  1  EX: taken branch/jump; redirect PC.
PCTargetE  input  32  EX: redirect target address.
InstrF  input  32  instruction word returned by instruction memory for PCF.
PCF  output  32  fetch address to instruction memory; bits [1:0] always 0.
InstrD  output  32  registered instruction.
PCD  output  32  registered PC of InstrD.
PCPlus4D  output  32  registered PCD+4.
ValidD  output  1  InstrD is a real fetched instruction (0 = bubble).
MisalignD  output  1  InstrD was fetched from a redirect whose target had bits [1:0] != 0.

Behaviour:
- Reset (rst=1 at clock edge) sets:
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignD=0.
  - Internal misalign_pending=0.
  - rst overrides every other input.
- PC register, priority order:
  - PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}. misalign_pending <= (PCTargetE[1:0]!=0). Redirect wins over StallF.
  - Else StallF=0: PCF <= PCF+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - Else: PCF holds.
- PCPlus4F is internal and combinational: PCF+4, 32-bit wrap.
- IF/ID register, priority order:
  - FlushD=1: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignD=0. Flush wins over StallD.
  - Else StallD=1: all D outputs hold.
  - Else (load): InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1, MisalignD<=misalign_pending.
- misalign_pending clearing:
  - Cleared on a load cycle, unless the same edge also has PCSrcE=1; the new redirect value then applies.
  - Held while D is stalled or flushed without a new redirect.
- Latency:
  - Instruction at PCF appears on InstrD one edge later, provided StallD=0 and FlushD=0.
  - Redirect at edge N: target fetched during cycle N+1, visible on InstrD after edge N+1.
- Expected hazard-unit usage:
  - Taken branch: PCSrcE=1 with FlushD=1 in the same cycle.
  - Load-use: StallF=StallD=1.
  - The block implements the priorities above for any combination, including illegal ones.
- Output behaviour:
  - No combinational path from any input to PCF. PCF changes only at clock edges.
  - All D outputs are registered.

Test Plan:
1. Reset and run: hold rst=1 for 2 cycles, release, memory returns 0xA0000000+PCF -> PCF=0,4,8,12 on successive cycles; first load gives InstrD=0xA0000000, PCD=0, PCPlus4D=4, ValidD=1.
2. Stall: at PCF=8 assert StallF=StallD=1 for 3 cycles -> PCF stays 8, InstrD/PCD (0xA0000004/4) stay frozen; after release PCF=12 next edge and InstrD=0xA0000008.
3. Taken branch: PCF=0x10, PCSrcE=1, PCTargetE=0x40, FlushD=1 -> next edge PCF=0x40, InstrD=NOP_INSTR, ValidD=0; following edge InstrD=mem[0x40], PCD=0x40, ValidD=1, MisalignD=0.
4. Misaligned target: PCSrcE=1, PCTargetE=0x102, FlushD=1 -> PCF=0x100; next load gives PCD=0x100, MisalignD=1; subsequent load gives MisalignD=0. Repeat with StallD=1 for 2 cycles before the load -> MisalignD=1 still delivered on the eventual load.
5. Simultaneous controls: PCSrcE=1, StallF=1, FlushD=1, StallD=1 -> PCF takes the target, D receives a bubble (ValidD=0, InstrD=0x00000013).
6. Wrap and mid-run reset: set PC via redirect to 0xFFFFFFFC -> next PCF=0x00000000, PCPlus4D for that instruction=0x00000000. Assert rst while StallD=1 and misalign pending -> all outputs return to reset values; the next load gives MisalignD=0.
